spi_reg_ctrl: RTL and testbench
===============================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum REG_ACK wait in CLK cycles, range 2..255.
REQ-002 Parameter ERR_BYTE, default 8'hEE: TX_DATA value substituted on a read timeout.
REQ-003 CLK  in  1  sole clock; all logic on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 MSG_START  in  1  one-cycle pulse when SSEL falls (message begins).
REQ-006 MSG_END  in  1  one-cycle pulse when SSEL rises (message ends).
REQ-007 RX_VALID  in  1  one-cycle pulse when a full SPI byte has been received.
REQ-008 RX_DATA  in  8  received byte, valid with RX_VALID.
REQ-009 TX_DATA  out  8  byte the SPI slave shifts out next; registered.
REQ-010 REG_ADDR  out  7  register-bank address; registered.
REQ-011 REG_WDATA  out  8  register write data; registered.
REQ-012 REG_WE  out  1  one-cycle write strobe.
REQ-013 REG_RE  out  1  read request, level, held until REG_ACK or timeout.
REQ-014 REG_ACK  in  1  read completion; REG_RDATA is valid in the same cycle.
REQ-015 REG_RDATA  in  8  read data.
REQ-016 ERR  out  1  sticky error flag (timeout or overrun).

Function
REQ-017 States: IDLE, CMD, WDATA, RFETCH, RREADY.
REQ-018 IDLE: MSG_START -> CMD; all other inputs ignored.
REQ-019 CMD: on RX_VALID, REG_ADDR <= RX_DATA[6:0]; RX_DATA[7]=1 -> RFETCH, RX_DATA[7]=0 -> WDATA.
REQ-020 WDATA: each RX_VALID -> next cycle REG_WE=1 for one cycle with REG_WDATA=RX_DATA and the current REG_ADDR; the cycle after, REG_ADDR increments.
REQ-021 RFETCH: REG_RE=1 from the first cycle in the state; on REG_ACK, TX_DATA <= REG_RDATA, REG_RE=0 the next cycle, REG_ADDR increments, -> RREADY.
REQ-022 RFETCH timeout: after TIMEOUT cycles without REG_ACK, TX_DATA <= ERR_BYTE, ERR <= 1, REG_ADDR increments, -> RREADY.
REQ-023 RREADY: RX_VALID (master dummy byte; data ignored) -> RFETCH for the next address.
REQ-024 RX_VALID while in RFETCH is an overrun: byte ignored, ERR <= 1, state unchanged.
REQ-025 REG_ADDR increments modulo 128 (7'h7F -> 7'h00).
REQ-026 TX_DATA = 8'h00 in IDLE, CMD and WDATA; it changes only on a REG_ACK/timeout capture or on a return to IDLE.
REQ-027 MSG_END in any state -> IDLE next cycle: REG_RE drops, TX_DATA <= 8'h00, timeout counter clears.
REQ-028 MSG_END with RX_VALID in the same cycle: the byte is processed first (a write still issues its REG_WE), then -> IDLE.
REQ-029 MSG_START outside IDLE: treated as MSG_END followed by MSG_START -> CMD.
REQ-030 MSG_START and MSG_END in the same cycle: MSG_END wins -> IDLE.
REQ-031 ERR clears only on RST.
REQ-032 REG_WE and REG_RE are never asserted in the same cycle.

Reset
REQ-033 RST asynchronously forces: state IDLE, TX_DATA=8'h00, REG_ADDR=7'h00, REG_WDATA=8'h00, REG_WE=0, REG_RE=0, ERR=0, timeout counter=0.
REQ-034 RST asserted mid-transaction aborts it; no REG_WE pulse is emitted after RST deasserts.

Structure
REQ-035 Package spi_reg_pkg holds: the state enum, CMD_READ_BIT=7, ADDR_W=7, and the default TIMEOUT and ERR_BYTE constants.
REQ-036 Single flat module with no sub-modules; the timeout counter is an 8-bit down-counter local to spi_reg_ctrl.

Verification
REQ-037 Write burst: START, bytes 8'h05, 8'hA1, 8'hB2, END -> REG_WE pulses write A1@05 and B2@06; REG_ADDR=07 afterwards; ERR=0.
REQ-038 Read with ACK latency 3: START, 8'h90, REG_RDATA=8'h3C -> REG_RE high 3 cycles, TX_DATA=3C; dummy byte -> next REG_RE on address 11.
REQ-039 Timeout: read command with REG_ACK never asserted, TIMEOUT=16 -> REG_RE drops after 16 cycles, TX_DATA=EE, ERR=1.
REQ-040 Wrap and abort: write command 8'h7F, data 8'h01, 8'h02 -> writes 01@7F and 02@00; MSG_END during RFETCH -> REG_RE drops next cycle, state IDLE.
REQ-041 Overrun and reset: RX_VALID during RFETCH -> ERR=1; RST asserted mid-write -> all outputs at reset values immediately, no REG_WE after release.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants and state encoding for the SPI-to-register-bank bridge.
package spi_reg_pkg;

   localparam int unsigned ADDR_W       = 7;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned CNT_W        = 8;
   localparam int unsigned CMD_READ_BIT = 7;

   localparam int unsigned       TIMEOUT_DEF  = 16;
   localparam logic [DATA_W-1:0] ERR_BYTE_DEF = 8'hEE;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_WDATA  = 3'd2;
   localparam logic [2:0] ST_RFETCH = 3'd3;
   localparam logic [2:0] ST_RREADY = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_CMD    = ST_CMD,
      S_WDATA  = ST_WDATA,
      S_RFETCH = ST_RFETCH,
      S_RREADY = ST_RREADY
   } state_e;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Decodes SPI byte stream into register-bank writes and read fetches.
// First byte is the command (bit 7 = read, bits 6:0 = start address); address auto-increments.
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int unsigned       TIMEOUT  = TIMEOUT_DEF,
   parameter logic [DATA_W-1:0] ERR_BYTE = ERR_BYTE_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              msg_start_i,
   input  logic              msg_end_i,
   input  logic              rx_valid_i,
   input  logic [DATA_W-1:0] rx_data_i,
   output logic [DATA_W-1:0] tx_data_o,
   output logic [ADDR_W-1:0] reg_addr_o,
   output logic [DATA_W-1:0] reg_wdata_o,
   output logic              reg_we_o,
   output logic              reg_re_o,
   input  logic              reg_ack_i,
   input  logic [DATA_W-1:0] reg_rdata_i,
   output logic              err_o
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic                re_q, re_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         tx_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         re_q    <= re_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      re_d    = re_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      // Post-increment after every write strobe, independent of the current state.
      if (we_q) begin
         addr_d = addr_q + ADDR_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (msg_start_i) begin
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            if (rx_valid_i) begin
               addr_d = rx_data_i[ADDR_W-1:0];
               if (rx_data_i[CMD_READ_BIT]) begin
                  state_d = S_RFETCH;
                  re_d    = 1'b1;
                  cnt_d   = CNT_W'(TIMEOUT - 1);
               end else begin
                  state_d = S_WDATA;
               end
            end
         end
         S_WDATA: begin
            if (rx_valid_i) begin
               we_d    = 1'b1;
               wdata_d = rx_data_i;
            end
         end
         S_RFETCH: begin
            if (rx_valid_i) begin
               err_d = 1'b1;
            end
            // Ack wins over a timeout expiring in the same cycle.
            if (reg_ack_i) begin
               tx_d    = reg_rdata_i;
               re_d    = 1'b0;
               addr_d  = addr_q + ADDR_W'(1);
               cnt_d   = '0;
               state_d = S_RREADY;
            end else if (cnt_q == '0) begin
               tx_d    = ERR_BYTE;
               err_d   = 1'b1;
               re_d    = 1'b0;
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_RREADY;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RREADY: begin
            if (rx_valid_i) begin
               state_d = S_RFETCH;
               re_d    = 1'b1;
               cnt_d   = CNT_W'(TIMEOUT - 1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Message boundary overrides the byte path; a mid-message start acts as end+start.
      if (msg_end_i || (msg_start_i && (state_q != S_IDLE))) begin
         state_d = msg_end_i ? S_IDLE : S_CMD;
         re_d    = 1'b0;
         tx_d    = '0;
         cnt_d   = '0;
      end
   end

   assign tx_data_o   = tx_q;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;
   assign reg_we_o    = we_q;
   assign reg_re_o    = re_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed scenarios then randomized messages against a transaction-level model.
module tb_spi_reg_ctrl;
   import spi_reg_pkg::*;

   localparam int unsigned TO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       msg_start, msg_end, rx_valid, reg_ack;
   logic [7:0] rx_data, reg_rdata;
   logic [7:0] tx_data, reg_wdata;
   logic [6:0] reg_addr;
   logic       reg_we, reg_re, err;

   spi_reg_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .msg_start_i (msg_start),
      .msg_end_i   (msg_end),
      .rx_valid_i  (rx_valid),
      .rx_data_i   (rx_data),
      .tx_data_o   (tx_data),
      .reg_addr_o  (reg_addr),
      .reg_wdata_o (reg_wdata),
      .reg_we_o    (reg_we),
      .reg_re_o    (reg_re),
      .reg_ack_i   (reg_ack),
      .reg_rdata_i (reg_rdata),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          excl_viol = 0;
   logic [7:0]  mem [128];
   int unsigned m_addr = 0;
   bit          m_err  = 1'b0;
   bit          in_msg = 1'b0;
   logic [7:0]  last_tx = 8'h00;

   always @(negedge clk) if (reg_we && reg_re) excl_viol++;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_tx"},    32'(tx_data),   0);
      check_eq({tag, "_addr"},  32'(reg_addr),  0);
      check_eq({tag, "_wdata"}, 32'(reg_wdata), 0);
      check_eq({tag, "_we"},    32'(reg_we),    0);
      check_eq({tag, "_re"},    32'(reg_re),    0);
      check_eq({tag, "_err"},   32'(err),       0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic start_msg();
      msg_start = 1'b1;
      tick();
      msg_start = 1'b0;
      in_msg = 1'b1;
   endtask

   task automatic end_msg();
      msg_end = 1'b1;
      tick();
      msg_end = 1'b0;
      in_msg = 1'b0;
      check_eq("end_re",  32'(reg_re),  0);
      check_eq("end_tx",  32'(tx_data), 0);
      check_eq("end_err", 32'(err),     32'(m_err));
   endtask

   task automatic restart_msg();
      msg_start = 1'b1;
      tick();
      msg_start = 1'b0;
      check_eq("rst_re", 32'(reg_re),  0);
      check_eq("rst_tx", 32'(tx_data), 0);
   endtask

   task automatic wr_cmd(input logic [6:0] a);
      send_byte({1'b0, a});
      m_addr = 32'(a);
      check_eq("wcmd_addr", 32'(reg_addr), 32'(m_addr));
      check_eq("wcmd_tx",   32'(tx_data),  0);
   endtask

   task automatic wr_byte(input logic [7:0] d);
      repeat ($urandom_range(2)) tick();
      send_byte(d);
      check_eq("wr_we",    32'(reg_we),    1);
      check_eq("wr_addr",  32'(reg_addr),  32'(m_addr));
      check_eq("wr_data",  32'(reg_wdata), 32'(d));
      check_eq("wr_re",    32'(reg_re),    0);
      tick();
      m_addr = (m_addr + 1) % 128;
      check_eq("wr_we_off", 32'(reg_we),   0);
      check_eq("wr_inc",    32'(reg_addr), 32'(m_addr));
      check_eq("wr_tx",     32'(tx_data),  0);
   endtask

   // Called in the first cycle of a fetch; lat > TO means no ack (timeout).
   task automatic do_fetch(input int lat, input int ovr_k, input int abort_k, output bit aborted);
      aborted = 1'b0;
      for (int k = 1; k <= int'(TO); k++) begin
         check_eq("rd_re",   32'(reg_re),   1);
         check_eq("rd_addr", 32'(reg_addr), 32'(m_addr));
         if (k == abort_k) begin
            msg_end = 1'b1;
            tick();
            msg_end = 1'b0;
            in_msg  = 1'b0;
            aborted = 1'b1;
            check_eq("abort_re",   32'(reg_re),   0);
            check_eq("abort_tx",   32'(tx_data),  0);
            check_eq("abort_addr", 32'(reg_addr), 32'(m_addr));
            return;
         end
         if (k == lat) begin
            reg_ack   = 1'b1;
            reg_rdata = mem[7'(m_addr)];
            tick();
            reg_ack   = 1'b0;
            reg_rdata = 8'($urandom);
            last_tx   = mem[7'(m_addr)];
            m_addr    = (m_addr + 1) % 128;
            check_eq("rd_re_drop", 32'(reg_re),   0);
            check_eq("rd_tx",      32'(tx_data),  32'(last_tx));
            check_eq("rd_inc",     32'(reg_addr), 32'(m_addr));
            return;
         end
         if (k == ovr_k) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
         end
         tick();
         rx_valid = 1'b0;
         if (k == ovr_k) begin
            m_err = 1'b1;
            check_eq("ovr_err", 32'(err), 1);
         end
      end
      last_tx = ERR_BYTE_DEF;
      m_err   = 1'b1;
      m_addr  = (m_addr + 1) % 128;
      check_eq("to_re",   32'(reg_re),   0);
      check_eq("to_tx",   32'(tx_data),  32'(ERR_BYTE_DEF));
      check_eq("to_err",  32'(err),      1);
      check_eq("to_addr", 32'(reg_addr), 32'(m_addr));
   endtask

   task automatic rd_cmd(input logic [6:0] a, input int lat, input int ovr_k, input int abort_k,
                         output bit aborted);
      send_byte({1'b1, a});
      m_addr = 32'(a);
      do_fetch(lat, ovr_k, abort_k, aborted);
   endtask

   task automatic rd_next(input int lat, input int ovr_k, input int abort_k, output bit aborted);
      repeat ($urandom_range(2)) tick();
      check_eq("rr_tx_hold", 32'(tx_data), 32'(last_tx));
      send_byte(8'($urandom));
      do_fetch(lat, ovr_k, abort_k, aborted);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
      m_addr = 0;
      m_err  = 1'b0;
      in_msg = 1'b0;
   endtask

   initial begin
      bit ab;
      bit we_seen;
      rst = 1'b1; msg_start = 1'b0; msg_end = 1'b0; rx_valid = 1'b0; reg_ack = 1'b0;
      rx_data = 8'h00; reg_rdata = 8'h00;
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      mem[16] = 8'h3C;
      repeat (2) @(posedge clk);
      #1;
      check_reset("por");
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Write burst A1@05, B2@06
      start_msg(); wr_cmd(7'h05); wr_byte(8'hA1); wr_byte(8'hB2); end_msg();
      check_eq("burst_addr", 32'(reg_addr), 7);

      // Read 0x10 with ack in third cycle, then dummy byte fetches 0x11
      start_msg(); rd_cmd(7'h10, 3, 0, 0, ab);
      rd_next(2, 0, 0, ab); end_msg();

      // Address wrap and abort during fetch
      start_msg(); wr_cmd(7'h7F); wr_byte(8'h01); wr_byte(8'h02); end_msg();
      start_msg(); rd_cmd(7'h22, 10, 0, 2, ab);
      send_byte(8'h05); send_byte(8'h11);
      check_eq("idle_we", 32'(reg_we), 0);
      check_eq("idle_re", 32'(reg_re), 0);

      // Start and end together: end wins, following bytes ignored
      start_msg(); wr_cmd(7'h40);
      msg_start = 1'b1; msg_end = 1'b1; tick(); msg_start = 1'b0; msg_end = 1'b0;
      send_byte(8'h01); send_byte(8'h77);
      check_eq("se_we", 32'(reg_we), 0);
      check_eq("se_re", 32'(reg_re), 0);

      // Overrun
      check_eq("pre_ovr_err", 32'(err), 0);
      start_msg(); rd_cmd(7'h20, 5, 2, 0, ab); end_msg();

      // Asynchronous reset mid-write
      start_msg(); wr_cmd(7'h30);
      rx_valid = 1'b1; rx_data = 8'h5A;
      #2 rst = 1'b1;
      #1 check_reset("async");
      @(posedge clk); #1;
      rx_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      we_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin tick(); we_seen |= reg_we; end
      check_eq("no_we_after_rst", 32'(we_seen), 0);
      m_addr = 0; m_err = 1'b0; in_msg = 1'b0;

      // Timeout
      start_msg(); rd_cmd(7'h40, 99, 0, 0, ab); end_msg();

      // Randomized messages
      apply_reset();
      for (int m = 0; m < 40; m++) begin
         if (!in_msg) start_msg();
         ab = 1'b0;
         if ($urandom_range(1) == 0) begin
            wr_cmd(7'($urandom));
            for (int i = 0; i < int'($urandom_range(4, 1)); i++) wr_byte(8'($urandom));
         end else begin
            int nrd;
            nrd = int'($urandom_range(3, 1));
            for (int i = 0; i < nrd && !ab; i++) begin
               int lat, ovr, abk;
               lat = int'($urandom_range(TO + 3, 1));
               ovr = 0;
               abk = 0;
               if (lat > 1 && $urandom_range(5) == 0)
                  ovr = int'($urandom_range((lat - 1 < int'(TO)) ? lat - 1 : int'(TO), 1));
               if (i == nrd - 1 && $urandom_range(5) == 0)
                  abk = int'($urandom_range(TO, 1));
               if (i == 0) rd_cmd(7'($urandom), lat, ovr, abk, ab);
               else        rd_next(lat, ovr, abk, ab);
            end
         end
         if (in_msg) begin
            if ($urandom_range(3) == 0) restart_msg();
            else end_msg();
         end
      end
      if (in_msg) end_msg();

      check_eq("we_re_exclusive", excl_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
